spi_frame_slave: RTL and testbench

SPI_FRAME_SLAVE -- requirements
Module: spi_frame_slave

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_sync.sv | 30 +++
 rtl/spi_frame_slave.sv | 236 +++++++++++++++++++++++
 tb/tb_spi_frame_slave.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI frame slave: field widths and FSM states.
package spi_pkg;

    localparam int INST_WIDTH  = 1;
    localparam int ADDR_WIDTH  = 7;
    localparam int DATA_WIDTH  = 8;
    localparam int FRAME_WIDTH = 16;

    // Frame progress: waiting for select, receiving inst+addr, data phase, finished.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin into the clk domain.
// RST_VAL is the pin's idle level so reset never looks like activity.
module spi_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two stages give the first flop a full cycle to resolve metastability.
    // NOTE: sequential state uses non-blocking assignments so both stages
    // sample their inputs at the same edge and the pipeline really is two deep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_frame_slave.sv
// SPI mode-0 slave that decodes 16-bit {inst, addr, data} frames into
// single-cycle register-map write/read strobes. All SPI pins are
// oversampled in the clk domain; sck must be at most clk/8.
module spi_frame_slave
    import spi_pkg::*;
#(
    parameter int INST_WIDTH = spi_pkg::INST_WIDTH,
    parameter int ADDR_WIDTH = spi_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = spi_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // SPI side
    input  logic                  sck_i,
    input  logic                  sdi_i,
    input  logic                  cs_ni,
    output logic                  sdo_o,
    // Register-map side
    output logic                  wr_en_o,
    output logic                  rd_en_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    input  logic [DATA_WIDTH-1:0] rdata_i
);

    localparam int FRAME_W = INST_WIDTH + ADDR_WIDTH + DATA_WIDTH;
    localparam int HDR_W   = INST_WIDTH + ADDR_WIDTH;
    localparam int CNT_W   = $clog2(FRAME_W + 1);

    localparam logic [CNT_W-1:0] LAST_HDR_CNT   = CNT_W'(HDR_W - 1);
    localparam logic [CNT_W-1:0] LAST_FRAME_CNT = CNT_W'(FRAME_W - 1);

    // ------------------------------------------------------------------
    // Synchronizers, reset to the idle bus levels.
    // ------------------------------------------------------------------
    logic sck_s;
    logic sdi_s;
    logic cs_n_s;

    spi_sync #(.RST_VAL(1'b0)) u_sync_sck (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (sck_i),
        .q_o  (sck_s)
    );

    spi_sync #(.RST_VAL(1'b0)) u_sync_sdi (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (sdi_i),
        .q_o  (sdi_s)
    );

    spi_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk  (clk),
        .rst_n(rst_n),
        .d_i  (cs_ni),
        .q_o  (cs_n_s)
    );

    // ------------------------------------------------------------------
    // Edge detection. The synchronizers come out of reset showing the idle
    // level for two cycles even if cs_n is really low; a frame interrupted
    // by reset must not be mistaken for a new one, so cs_n falls are only
    // honoured once cs_n has been seen high after the pipeline has flushed.
    // ------------------------------------------------------------------
    logic       sck_prev_q;
    logic       cs_prev_q;
    logic [1:0] settle_q;
    logic       armed_q;

    logic sck_rise;
    logic sck_fall;
    logic cs_fall;
    logic cs_rise;

    // Previous-sample registers for edge detection and the post-reset arming flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
            settle_q   <= 2'd0;
            armed_q    <= 1'b0;
        end else begin
            sck_prev_q <= sck_s;
            cs_prev_q  <= cs_n_s;
            if (settle_q != 2'd2) begin
                settle_q <= settle_q + 2'd1;
            end
            if (settle_q == 2'd2 && cs_n_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_fall  = armed_q & cs_prev_q & ~cs_n_s;
    assign cs_rise  = ~cs_prev_q & cs_n_s;

    // ------------------------------------------------------------------
    // Frame FSM and datapath.
    // ------------------------------------------------------------------
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [FRAME_W-1:0]    rx_q,    rx_d;
    logic [DATA_WIDTH-1:0] tx_q,    tx_d;
    logic                  sdo_q,   sdo_d;
    logic                  wr_en_q, wr_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic [FRAME_W-1:0]    rx_shift;
    logic                  hdr_is_read;
    logic                  frame_is_read;

    // Receive register as it will look after the current sdi sample is shifted in.
    assign rx_shift      = {rx_q[FRAME_W-2:0], sdi_s};
    assign hdr_is_read   = rx_shift[ADDR_WIDTH +: INST_WIDTH] != '0;
    assign frame_is_read = rx_shift[FRAME_W-1 -: INST_WIDTH] != '0;

    // State register and all frame-level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rx_q    <= '0;
            tx_q    <= '0;
            sdo_q   <= 1'b0;
            wr_en_q <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rx_q    <= rx_d;
            tx_q    <= tx_d;
            sdo_q   <= sdo_d;
            wr_en_q <= wr_en_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Next-state and datapath decode driven by synchronized cs/sck edges.
    // NOTE: every signal gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rx_d    = rx_q;
        tx_d    = tx_q;
        sdo_d   = sdo_q;
        wr_en_d = 1'b0;
        rd_en_d = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        // Register-map read data arrives the cycle after the request strobe.
        if (rd_en_q) begin
            tx_d = rdata_i;
        end

        if (cs_rise) begin
            state_d = IDLE;
            sdo_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    sdo_d = 1'b0;
                    if (cs_fall) begin
                        state_d = HEADER;
                        cnt_d   = '0;
                        rx_d    = '0;
                        tx_d    = '0;
                    end
                end

                HEADER: begin
                    sdo_d = 1'b0;
                    if (sck_rise) begin
                        rx_d  = rx_shift;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_HDR_CNT) begin
                            state_d = DATA;
                            addr_d  = rx_shift[ADDR_WIDTH-1:0];
                            if (hdr_is_read) begin
                                rd_en_d = 1'b1;
                            end else begin
                                tx_d = '0;
                            end
                        end
                    end
                end

                DATA: begin
                    if (sck_fall) begin
                        sdo_d = tx_q[DATA_WIDTH-1];
                        tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    end
                    if (sck_rise) begin
                        rx_d  = rx_shift;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == LAST_FRAME_CNT) begin
                            state_d = DONE;
                            sdo_d   = 1'b0;
                            wdata_d = rx_shift[DATA_WIDTH-1:0];
                            if (!frame_is_read) begin
                                wr_en_d = 1'b1;
                            end
                        end
                    end
                end

                DONE: begin
                    sdo_d = 1'b0;
                end

                default: begin
                    state_d = IDLE;
                    sdo_d   = 1'b0;
                end
            endcase
        end
    end

    assign sdo_o   = sdo_q;
    assign wr_en_o = wr_en_q;
    assign rd_en_o = rd_en_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule

// File: tb/tb_spi_frame_slave.sv
// Directed bench for spi_frame_slave: a bit-banged SPI master, a small
// register-map model behind the slave, and a scoreboard of expected strobes.
`timescale 1ns/1ps
module tb_spi_frame_slave;

    localparam int HALF = 8; // clk cycles per half sck period (sck = clk/16)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sck_i = 1'b0;
    logic       sdi_i = 1'b0;
    logic       cs_ni = 1'b1;
    logic       sdo_o;
    logic       wr_en_o;
    logic       rd_en_o;
    logic [6:0] addr_o;
    logic [7:0] wdata_o;
    logic [7:0] rdata_i;

    spi_frame_slave dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sck_i  (sck_i),
        .sdi_i  (sdi_i),
        .cs_ni  (cs_ni),
        .sdo_o  (sdo_o),
        .wr_en_o(wr_en_o),
        .rd_en_o(rd_en_o),
        .addr_o (addr_o),
        .wdata_o(wdata_o),
        .rdata_i(rdata_i)
    );

    always #5 clk = ~clk;

    // Register map behind the slave.
    logic [7:0] regmap [128];
    assign rdata_i = regmap[addr_o];

    typedef struct {
        bit         is_write;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t sb_e;
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Strobe monitor: every strobe must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && (wr_en_o || rd_en_o)) begin
            check("strobe_exclusive", 32'(wr_en_o & rd_en_o), 32'd0);
            check("strobe_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                sb_e = sb.pop_front();
                check("strobe_kind_is_write", 32'(wr_en_o), 32'(sb_e.is_write));
                check("strobe_addr", 32'(addr_o), 32'(sb_e.addr));
                if (sb_e.is_write) begin
                    check("strobe_wdata", 32'(wdata_o), 32'(sb_e.data));
                end
            end
            if (wr_en_o) begin
                regmap[addr_o] = wdata_o;
            end
        end
    end

    // One SPI transaction of nbits sck cycles; rst_at >= 0 pulses reset at that bit.
    task automatic frame(input logic inst, input logic [6:0] addr, input logic [7:0] data,
                         input int nbits, input int rst_at, output logic [7:0] miso);
        logic [15:0] f;
        f    = {inst, addr, data};
        miso = '0;
        @(posedge clk);
        cs_ni = 1'b0;
        repeat (HALF) @(posedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                rst_n = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("midrst_addr", 32'(addr_o), 32'd0);
                check("midrst_wdata", 32'(wdata_o), 32'd0);
                check("midrst_wr_en", 32'(wr_en_o), 32'd0);
                check("midrst_rd_en", 32'(rd_en_o), 32'd0);
                check("midrst_sdo", 32'(sdo_o), 32'd0);
                rst_n = 1'b1;
            end
            sdi_i = (i < 16) ? f[15-i] : 1'b0;
            repeat (HALF) @(posedge clk);
            sck_i = 1'b1;
            #1;
            if (i < 8) check("sdo_in_header", 32'(sdo_o), 32'd0);
            if (i >= 8 && i < 16) miso = {miso[6:0], sdo_o};
            if (i >= 16) check("sdo_after_bit16", 32'(sdo_o), 32'd0);
            repeat (HALF) @(posedge clk);
            sck_i = 1'b0;
        end
        repeat (HALF) @(posedge clk);
        cs_ni = 1'b1;
        repeat (HALF) @(posedge clk);
        #1;
        check("sdo_cs_high", 32'(sdo_o), 32'd0);
    endtask

    logic [7:0] miso;

    initial begin
        for (int i = 0; i < 128; i++) regmap[i] = 8'h00;
        regmap[5] = 8'h3C;

        // Reset values
        repeat (4) @(posedge clk);
        #1;
        check("rst_addr", 32'(addr_o), 32'd0);
        check("rst_wdata", 32'(wdata_o), 32'd0);
        check("rst_wr_en", 32'(wr_en_o), 32'd0);
        check("rst_rd_en", 32'(rd_en_o), 32'd0);
        check("rst_sdo", 32'(sdo_o), 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);

        // Write 0x03 = 0xA5
        sb.push_back('{1'b1, 7'h03, 8'hA5});
        frame(1'b0, 7'h03, 8'hA5, 16, -1, miso);
        check("wr1_drained", 32'(sb.size()), 32'd0);
        check("wr1_addr", 32'(addr_o), 32'h03);
        check("wr1_wdata", 32'(wdata_o), 32'hA5);

        // Read 0x05 with register value 0x3C
        sb.push_back('{1'b0, 7'h05, 8'h00});
        frame(1'b1, 7'h05, 8'h00, 16, -1, miso);
        check("rd1_drained", 32'(sb.size()), 32'd0);
        check("rd1_addr", 32'(addr_o), 32'h05);
        check("rd1_miso", 32'(miso), 32'h3C);

        // Aborted write after 12 bits: no strobe, wdata keeps last value
        frame(1'b0, 7'h01, 8'h77, 12, -1, miso);
        check("abort_drained", 32'(sb.size()), 32'd0);
        check("abort_wdata_held", 32'(wdata_o), 32'h00);
        check("abort_addr", 32'(addr_o), 32'h01);

        // Full write 0x01 = 0xFF afterwards
        sb.push_back('{1'b1, 7'h01, 8'hFF});
        frame(1'b0, 7'h01, 8'hFF, 16, -1, miso);
        check("wr2_drained", 32'(sb.size()), 32'd0);
        check("wr2_wdata", 32'(wdata_o), 32'hFF);

        // 20 sck cycles in one frame: extra edges ignored
        sb.push_back('{1'b1, 7'h04, 8'h55});
        frame(1'b0, 7'h04, 8'h55, 20, -1, miso);
        check("long_drained", 32'(sb.size()), 32'd0);
        check("long_wdata", 32'(wdata_o), 32'h55);
        check("long_addr", 32'(addr_o), 32'h04);

        // Reset during bit 10: frame discarded, outputs back to reset values
        frame(1'b0, 7'h06, 8'h99, 16, 10, miso);
        check("midrst_drained", 32'(sb.size()), 32'd0);
        check("midrst_addr_after", 32'(addr_o), 32'd0);
        check("midrst_wdata_after", 32'(wdata_o), 32'd0);

        // Next complete frame after reset works
        sb.push_back('{1'b1, 7'h07, 8'hC3});
        frame(1'b0, 7'h07, 8'hC3, 16, -1, miso);
        check("postrst_drained", 32'(sb.size()), 32'd0);
        check("postrst_wdata", 32'(wdata_o), 32'hC3);

        // Back-to-back: write 0x02 = 0x0F, 1 us gap, read 0x02
        sb.push_back('{1'b1, 7'h02, 8'h0F});
        frame(1'b0, 7'h02, 8'h0F, 16, -1, miso);
        repeat (100) @(posedge clk);
        sb.push_back('{1'b0, 7'h02, 8'h00});
        frame(1'b1, 7'h02, 8'h00, 16, -1, miso);
        check("b2b_drained", 32'(sb.size()), 32'd0);
        check("b2b_miso", 32'(miso), 32'h0F);

        repeat (10) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
